// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lock sequences and registered load return.
// Optional: define DMEM_ARB_RR_EN for round-robin IDLE arbitration (no starvation counter).
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [DM_ADDRESS-1:0] addr0,
  input  logic [DM_ADDRESS-1:0] addr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_W-1:0]     rdata0,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

`ifdef DMEM_ARB_RR_EN
  logic prio1_q, prio1_d;
`else
  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);
  logic [7:0] wait_q, wait_d;
`endif

  // Grant selection, lock state transitions and fairness bookkeeping
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
`ifdef DMEM_ARB_RR_EN
    prio1_d = prio1_q;
`else
    wait_d  = wait_q;
`endif
    if (!reset) begin
      case (state_q)
        LOCK0: gnt0 = req0;
        LOCK1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            gnt0    = !prio1_q;
            gnt1    = prio1_q;
            prio1_d = !prio1_q;
`else
            gnt1 = (wait_q >= MaxWait);
            gnt0 = !gnt1;
`endif
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
      if (gnt0) begin
        state_d = lock0 ? LOCK0 : IDLE;
      end else if (gnt1) begin
        state_d = lock1 ? LOCK1 : IDLE;
      end
`ifndef DMEM_ARB_RR_EN
      if (req1 && !gnt1) begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      end else begin
        wait_d = 8'd0;
      end
`endif
    end
  end

  // Drive the memory from the winning port, idle-zero otherwise
  always_comb begin
    MemRead  = (gnt0 && !we0) || (gnt1 && !we1);
    MemWrite = (gnt0 && we0) || (gnt1 && we1);
    a        = '0;
    wd       = '0;
    Funct3   = 3'b000;
    if (gnt0) begin
      a      = addr0;
      wd     = wdata0;
      Funct3 = funct3_0;
    end else if (gnt1) begin
      a      = addr1;
      wd     = wdata1;
      Funct3 = funct3_1;
    end
  end

  // Capture load data at the edge closing the grant cycle
  always_comb begin
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? rd : rdata0_q;
    rdata1_d  = rvalid1_d ? rd : rdata1_q;
  end

  // State and return registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      prio1_q   <= 1'b0;
`else
      wait_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      prio1_q   <= prio1_d;
`else
      wait_q    <= wait_d;
`endif
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign owner   = state_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-ported data memory (9-bit byte address, Funct3-encoded size).
- Requester 0 is the core load/store stage; requester 1 is a secondary master (debug/DMA loader).
- Grants at most one access per cycle and drives the memory's MemRead/MemWrite/a/wd/Funct3.
- Registers returned read data with a per-port valid pulse; supports locked back-to-back sequences and starvation protection.

Parameters:
- DM_ADDRESS, 9, memory address width.
- DATA_W, 32, data width.
- MAX_WAIT, 8, consecutive losing cycles after which requester 1 is forced to win (range 1..255).

Ports:
- clk  in  1  clock; memory is clocked on ~clk by the memory block.
- reset  in  1  synchronous, active-high reset.
- req0/req1  in  1  access request, held until granted.
- we0/we1  in  1  1 = store, 0 = load.
- lock0/lock1  in  1  when granted with lock=1, port keeps ownership for its next request.
- addr0/addr1  in  DM_ADDRESS  byte address.
- wdata0/wdata1  in  DATA_W  store data.
- funct3_0/funct3_1  in  3  access size/sign code (LW/LB/LBU/LH/SW/SB/SH encoding).
- gnt0/gnt1  out  1  combinational grant; request accepted this cycle.
- rvalid0/rvalid1  out  1  one-cycle pulse, load data valid.
- rdata0/rdata1  out  DATA_W  registered load data, held until the next rvalid on that port.
- MemRead, MemWrite  out  1  to memory.
- a  out  DM_ADDRESS  to memory.
- wd  out  DATA_W  to memory.
- Funct3  out  3  to memory.
- rd  in  DATA_W  read data from memory.
- owner  out  2  debug: 2'b00 none, 01 port0 locked, 10 port1 locked.

Behaviour:
- Reset (sync, active-high):
  - gnt*, rvalid*, MemRead, MemWrite = 0; rdata* = 0; owner = 00; wait counter = 0; state = IDLE.
- States: IDLE, LOCK0, LOCK1.
  - IDLE: grant rules below.
  - LOCKn: only port n may be granted, even if the other port requests and the wait counter is saturated.
- Transitions:
  - Granting port n with lockn=1 moves to LOCKn.
  - A grant in LOCKn with lockn=0 returns to IDLE.
  - LOCKn with reqn=0 stays in LOCKn. The lock holder must release by issuing an unlocked access.
- IDLE grant rules:
  - Only one port requesting: that port wins.
  - Both requesting: port 0 wins, unless wait counter ≥ MAX_WAIT, in which case port 1 wins.
- Wait counter (8-bit):
  - Increments each cycle req1=1 and gnt1=0, saturating at 255.
  - Clears on gnt1 or req1=0.
- Memory drive:
  - In the grant cycle, drive a/wd/Funct3 from the winning port; MemRead = ~we, MemWrite = we.
  - With no grant, MemRead = MemWrite = 0; a/wd/Funct3 = 0.
- Latency:
  - Store completes within the grant cycle (memory negedge); no rvalid for stores.
  - Load: rd is sampled at the posedge ending the grant cycle; rvalidn = 1 and rdatan = sampled value in the following cycle. Load-to-data latency is 1.
- Back-to-back:
  - A new grant is allowed every cycle, including a load immediately followed by a store to the same address. The load returns the old value.
- Simultaneous: rvalid for the previous load and gnt for a new request on the same port may be high in the same cycle.
- Reset mid-lock: returns to IDLE and drops any pending rvalid.
- Requests with we=1 and Funct3 not in {SW, SB, SH} are passed through unchanged; the memory's default handling applies.
- Address is passed unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- When defined: IDLE arbitration is round-robin. The port that did not win the last contended grant wins the next contended one, and the starvation counter/MAX_WAIT logic is removed.
- When undefined: fixed priority port 0 plus starvation override as specified above.
- Lock behaviour is identical in both builds.

Test Plan:
- Single load: port0 load LW addr 0x010, memory holds 0xDEADBEEF at 0x010 -> gnt0 in cycle 0, rvalid0 = 1 with rdata0 = 0xDEADBEEF in cycle 1, rvalid1 stays 0.
- Contention: both ports request stores continuously -> port0 wins cycles 0..7, port1 granted in cycle 8 (MAX_WAIT = 8), counter cleared; with DMEM_ARB_RR_EN, grants alternate 0,1,0,1.
- Lock: port1 SW lock1 = 1 to 0x020, then LW lock1 = 0 from 0x020 while req0 is held high -> port0 not granted until the cycle after the unlocked load; rdata1 = stored value; owner goes 10 -> 00.
- Store/load pipelining: port0 SB 0x55 to 0x004, then LBU 0x004 next cycle -> rdata0 = 0x00000055 in cycle 2, one grant per cycle, no bubbles.
- Reset mid-operation: assert reset during LOCK0 with a load outstanding -> next cycle state IDLE, rvalid0 = 0, owner = 00, MemRead = MemWrite = 0.
- Idle: no requests for 10 cycles -> MemRead = MemWrite = 0 throughout, wait counter remains 0.
